sqrt_share_arbiter: RTL and testbench

Controller that time-shares the single `sqrt_4_unsigned` square-root unit among `NUM_REQ` normalization lanes. It accepts one operand per cycle via round-robin arbitration and clamps it to the unit's valid domain. It tracks each operand's requester tag through the unit's fixed pipeline, then buffers results in a credit-protected output FIFO with a valid/ready handshake. It sits between the per-lane variance stages and the reciprocal/scale stage of the matrix normalization path.

---
 rtl/sqrt_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_sqrt_share_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_share_arbiter.sv
// Round-robin front end that time-shares one fixed-latency sqrt unit across NUM_REQ lanes,
// tracks requester tags alongside the unit and buffers results in a credit-guarded FIFO.
module sqrt_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TAG_W      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SQRT_LAT   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*11-1:0]  req_x,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [10:0]            sq_x,
  input  logic [10:0]            sq_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [10:0]            out_y,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_clamped,
  output logic                   idle
);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;
  localparam logic [10:0] X_MIN = 11'd512;

  typedef struct packed {
    logic [10:0]      y;
    logic [TAG_W-1:0] tag;
    logic             clamped;
  } entry_t;

  logic [TAG_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]                credits_q, credits_d;
  logic [10:0]                  sq_x_q, sq_x_d;
  logic [SQRT_LAT:0]            pv_q, pv_d;
  logic [SQRT_LAT:0]            pcl_q, pcl_d;
  logic [SQRT_LAT:0][TAG_W-1:0] ptag_q, ptag_d;
  entry_t                       mem_q [FIFO_DEPTH];
  entry_t                       mem_d [FIFO_DEPTH];
  logic [FW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                cnt_q, cnt_d;

  logic             gnt_found;
  logic [TAG_W-1:0] gnt_idx;
  logic [10:0]      x_sel, x_cl;
  logic             x_low, accept, push, pop;
  entry_t           head;

  // Scan from rr_ptr upward with wrap; first valid lane wins.
  always_comb begin
    logic [TAG_W:0] sum;
    sum       = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + (TAG_W+1)'(i);
      if (sum >= (TAG_W+1)'(NUM_REQ)) sum = sum - (TAG_W+1)'(NUM_REQ);
      if (!gnt_found && req_valid[sum[TAG_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = sum[TAG_W-1:0];
      end
    end
  end

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_idx == TAG_W'(i)) x_sel = req_x[i*11 +: 11];
  end

  assign x_low  = x_sel < X_MIN;
  assign x_cl   = x_low ? X_MIN : x_sel;
  assign accept = gnt_found && (credits_q != '0);
  assign push   = pv_q[SQRT_LAT];
  assign pop    = out_valid & out_ready;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept)
      rr_ptr_d = (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
    sq_x_d = accept ? x_cl : sq_x_q;
    pv_d   = {pv_q[SQRT_LAT-1:0], accept};
    pcl_d  = {pcl_q[SQRT_LAT-1:0], x_low};
    ptag_d = {ptag_q[SQRT_LAT-1:0], gnt_idx};

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{y: sq_y, tag: ptag_q[SQRT_LAT], clamped: pcl_q[SQRT_LAT]};
      wr_ptr_d        = wr_ptr_q + FW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + FW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    // Credits cover FIFO slots plus results still inside the unit.
    credits_d = credits_q - CW'(accept) + CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      credits_q <= CW'(FIFO_DEPTH);
      sq_x_q    <= '0;
      pv_q      <= '0;
      pcl_q     <= '0;
      ptag_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      credits_q <= credits_d;
      sq_x_q    <= sq_x_d;
      pv_q      <= pv_d;
      pcl_q     <= pcl_d;
      ptag_q    <= ptag_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk)
    if (!reset) assert (!(push && cnt_q == CW'(FIFO_DEPTH)));

  assign head        = mem_q[rd_ptr_q];
  assign sq_x        = sq_x_q;
  assign out_valid   = (cnt_q != '0);
  assign out_y       = head.y;
  assign out_tag     = head.tag;
  assign out_clamped = head.clamped;
  assign idle        = (pv_q == '0) && (cnt_q == '0);

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Randomized and directed bench for sqrt_share_arbiter against a queue-based model of
// accepted operands; includes a behavioural fixed-latency sqrt unit.
module tb_sqrt_share_arbiter;
  localparam int NUM_REQ = 4, TAG_W = 2, FIFO_DEPTH = 4, SQRT_LAT = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*11-1:0] req_x;
  logic [NUM_REQ-1:0]    req_ready;
  logic [10:0]           sq_x, sq_y;
  logic                  out_valid, out_ready;
  logic [10:0]           out_y;
  logic [TAG_W-1:0]      out_tag;
  logic                  out_clamped, idle;

  sqrt_share_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .FIFO_DEPTH(FIFO_DEPTH),
                       .SQRT_LAT(SQRT_LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .sq_x(sq_x), .sq_y(sq_y), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_tag(out_tag), .out_clamped(out_clamped), .idle(idle));

  always #5 clk = ~clk;

  function automatic int isqrt(input int v);
    int r = 0;
    for (int b = 11; b >= 0; b--)
      if ((r + (1 << b)) * (r + (1 << b)) <= v) r += (1 << b);
    return r;
  endfunction

  // Shared unit: Q2.9 in, Q1.10 out, SQRT_LAT cycles after sq_x.
  logic [10:0] su_pipe [SQRT_LAT];
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SQRT_LAT; k++) su_pipe[k] <= '0;
    end else begin
      su_pipe[0] <= 11'(isqrt(int'(sq_x) * 2048));
      for (int k = 1; k < SQRT_LAT; k++) su_pipe[k] <= su_pipe[k-1];
    end
  end
  assign sq_y = su_pipe[SQRT_LAT-1];

  typedef struct { int t; int tag; bit cl; int y; } item_t;
  typedef struct { int tag; int cl; int y; } obs_t;
  item_t q[$];
  obs_t  pl[$];

  int n_vec = 0, n_bad = 0;
  int cyc = 0, n_acc = 0, last_g = -1, m_rr = 0, m_sqx = 0, p_req = 0;
  bit pend [NUM_REQ];
  logic [10:0] px [NUM_REQ];
  bit ordy = 0, rst_drv = 0, refill = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [10:0] rand_x();
    case ($urandom_range(0, 4))
      0: return 11'($urandom_range(0, 511));
      1: return ($urandom_range(0, 1) != 0) ? 11'd511 : 11'd512;
      2: return 11'd2047;
      default: return 11'($urandom_range(0, 2047));
    endcase
  endfunction

  task automatic step();
    int g, i, xc;
    bit exp_ov;
    logic [NUM_REQ-1:0] exp_rdy;
    reset = rst_drv;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_valid[k]       = pend[k] & ~rst_drv;
      req_x[k*11 +: 11]  = px[k];
    end
    out_ready = ordy;
    #2;
    if (rst_drv) begin
      q.delete();
      m_rr  = 0;
      m_sqx = 0;
    end else begin
      g = -1;
      if (FIFO_DEPTH - q.size() > 0)
        for (int k = 0; k < NUM_REQ; k++) begin
          i = (m_rr + k) % NUM_REQ;
          if (g < 0 && pend[i]) g = i;
        end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check_eq("req_ready", req_ready, exp_rdy);
      check_eq("sq_x", sq_x, m_sqx);
      check_eq("idle", idle, q.size() == 0);
      exp_ov = q.size() > 0 && q[0].t + SQRT_LAT + 2 <= cyc;
      check_eq("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        check_eq("out_y", out_y, q[0].y);
        check_eq("out_tag", out_tag, q[0].tag);
        check_eq("out_clamped", out_clamped, q[0].cl);
        if (ordy) begin
          pl.push_back('{int'(out_tag), int'(out_clamped), int'(out_y)});
          void'(q.pop_front());
        end
      end
      if (g >= 0) begin
        xc = (px[g] < 512) ? 512 : int'(px[g]);
        q.push_back('{cyc, g, px[g] < 512, isqrt(xc * 2048)});
        m_sqx  = xc;
        m_rr   = (g + 1) % NUM_REQ;
        last_g = g;
        n_acc++;
        if (refill) px[g] = rand_x();
        else pend[g] = 1'b0;
      end
      for (int k = 0; k < NUM_REQ; k++)
        if (!pend[k] && $urandom_range(0, 99) < p_req) begin
          pend[k] = 1'b1;
          px[k]   = rand_x();
        end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic lanes(input bit on);
    for (int k = 0; k < NUM_REQ; k++) begin
      pend[k] = on;
      px[k]   = rand_x();
    end
  endtask

  initial begin
    int a0, prev;
    lanes(1'b0);
    rst_drv = 1'b1;
    run(2);
    rst_drv = 1'b0;
    check_eq("rst_sq_x", sq_x, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_y", out_y, 0);
    check_eq("rst_out_tag", out_tag, 0);
    check_eq("rst_out_clamped", out_clamped, 0);
    check_eq("rst_idle", idle, 1);

    // single request from lane 2, x = 2.0
    ordy = 1'b1;
    pend[2] = 1'b1;
    px[2]   = 11'd1024;
    pl.delete();
    run(8);
    check_eq("single_pops", pl.size(), 1);
    if (pl.size() == 1) begin
      check_eq("single_tag", pl[0].tag, 2);
      check_eq("single_y", pl[0].y, 1448);
    end

    // round-robin with all lanes busy
    refill = 1'b1;
    lanes(1'b1);
    prev = -1;
    for (int k = 0; k < 24; k++) begin
      a0 = n_acc;
      step();
      if (n_acc != a0) begin
        if (prev >= 0) check_eq("rr_order", last_g, (prev + 1) % NUM_REQ);
        prev = last_g;
      end
    end
    refill = 1'b0;
    lanes(1'b0);
    run(10);

    // credit stall
    refill = 1'b1;
    ordy = 1'b0;
    pend[0] = 1'b1;
    a0 = n_acc;
    run(10);
    check_eq("stall_accepts", n_acc - a0, FIFO_DEPTH);
    a0 = n_acc;
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    run(6);
    check_eq("stall_one_more", n_acc - a0, 1);

    // full FIFO with continuous pop while requests continue
    ordy = 1'b1;
    lanes(1'b1);
    run(30);
    refill = 1'b0;
    lanes(1'b0);
    run(10);

    // clamp
    pl.delete();
    pend[1] = 1'b1;
    px[1]   = 11'd300;
    step();
    pend[1] = 1'b1;
    px[1]   = 11'd2047;
    run(8);
    check_eq("clamp_pops", pl.size(), 2);
    if (pl.size() == 2) begin
      check_eq("clamp_flag_lo", pl[0].cl, 1);
      check_eq("clamp_y_lo", pl[0].y, 1024);
      check_eq("clamp_flag_hi", pl[1].cl, 0);
      check_eq("clamp_y_hi", pl[1].y, 2047);
    end

    // reset with two results in the FIFO and two in flight
    refill = 1'b1;
    ordy = 1'b0;
    pend[0] = 1'b1;
    run(4);
    refill = 1'b0;
    pend[0] = 1'b0;
    run(2);
    check_eq("pre_rst_valid", out_valid, 1);
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    check_eq("post_rst_valid", out_valid, 0);
    run(6);
    refill = 1'b1;
    pend[0] = 1'b1;
    a0 = n_acc;
    run(10);
    check_eq("post_rst_credits", n_acc - a0, FIFO_DEPTH);
    refill = 1'b0;
    lanes(1'b0);
    ordy = 1'b1;
    run(10);

    // randomized traffic with occasional resets
    p_req = 40;
    for (int k = 0; k < 1500; k++) begin
      ordy    = ($urandom_range(0, 3) != 0);
      rst_drv = ($urandom_range(0, 299) == 0);
      step();
    end
    rst_drv = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
